// File: rtl/sync_fifo_status.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable registered or show-ahead read port.
module sync_fifo_status #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int AF_THRESH  = MEM_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int SHOW_AHEAD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] DataInput,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] DataOutput,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_en;
    logic                  rd_en;

    // Accept decisions use the registered flags, so a full FIFO can still pop and an empty one push.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            count_next = count - CNT_ONE;
        end
    end

    // Storage is deliberately left out of reset; only pointers and status are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= DataInput;
        end
    end

    // Status flags are derived from count_next so they line up with count every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count        <= count_next;
            full         <= (count_next == CNT_FULL);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CNT_AF);
            almost_empty <= (count_next <= CNT_AE);
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            assign DataOutput = mem[rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (rd_en) begin
                    data_reg <= mem[rd_ptr];
                end
            end

            assign DataOutput = data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_status.sv
// Bench for sync_fifo_status: three instances (registered read, show-ahead, custom thresholds)
// each checked every cycle against a queue-based reference model.
module tb_sync_fifo_status;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_v   [3];
    logic          push_v  [3];
    logic          pop_v   [3];
    logic          clr_v   [3];
    logic [DW-1:0] din_v   [3];
    logic [DW-1:0] dout_v  [3];
    logic          full_v  [3];
    logic          empty_v [3];
    logic          af_v    [3];
    logic          ae_v    [3];
    logic          ovf_v   [3];
    logic          udf_v   [3];
    logic [CW-1:0] cnt_v   [3];

    // Per-instance model configuration and state
    int            af_th [3] = '{15, 15, 12};
    int            ae_th [3] = '{1, 1, 3};
    int            sa    [3] = '{0, 1, 0};
    logic          m_ovf [3];
    logic          m_udf [3];
    logic [DW-1:0] m_last[3];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];

    int assertions = 0;
    int failures   = 0;

    sync_fifo_status #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .SHOW_AHEAD(0)) dut_reg (
        .clk(clk), .reset(rst_v[0]), .DataInput(din_v[0]), .push(push_v[0]), .pop(pop_v[0]),
        .clear_err(clr_v[0]), .DataOutput(dout_v[0]), .full(full_v[0]), .empty(empty_v[0]),
        .almost_full(af_v[0]), .almost_empty(ae_v[0]), .count(cnt_v[0]),
        .overflow(ovf_v[0]), .underflow(udf_v[0])
    );

    sync_fifo_status #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .SHOW_AHEAD(1)) dut_sa (
        .clk(clk), .reset(rst_v[1]), .DataInput(din_v[1]), .push(push_v[1]), .pop(pop_v[1]),
        .clear_err(clr_v[1]), .DataOutput(dout_v[1]), .full(full_v[1]), .empty(empty_v[1]),
        .almost_full(af_v[1]), .almost_empty(ae_v[1]), .count(cnt_v[1]),
        .overflow(ovf_v[1]), .underflow(udf_v[1])
    );

    sync_fifo_status #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .AF_THRESH(12), .AE_THRESH(3),
                       .SHOW_AHEAD(0)) dut_th (
        .clk(clk), .reset(rst_v[2]), .DataInput(din_v[2]), .push(push_v[2]), .pop(pop_v[2]),
        .clear_err(clr_v[2]), .DataOutput(dout_v[2]), .full(full_v[2]), .empty(empty_v[2]),
        .almost_full(af_v[2]), .almost_empty(ae_v[2]), .count(cnt_v[2]),
        .overflow(ovf_v[2]), .underflow(udf_v[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle on instance id, advance the model, then compare every output.
    task automatic applyStimulus(input int id, input logic rst, input logic p, input logic r,
                                 input logic c, input logic [DW-1:0] d);
        logic [DW-1:0] q[$];
        logic [DW-1:0] w;
        logic          mfull;
        logic          mempty;
        string         pfx;

        rst_v[id]  = rst;
        push_v[id] = p;
        pop_v[id]  = r;
        clr_v[id]  = c;
        din_v[id]  = d;
        @(posedge clk);
        #1;
        rst_v[id]  = 1'b0;
        push_v[id] = 1'b0;
        pop_v[id]  = 1'b0;
        clr_v[id]  = 1'b0;

        case (id)
            0:       q = q0;
            1:       q = q1;
            default: q = q2;
        endcase
        mfull  = (q.size() == DEPTH);
        mempty = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_ovf[id]  = 1'b0;
            m_udf[id]  = 1'b0;
            m_last[id] = '0;
        end else begin
            if (p && mfull) m_ovf[id] = 1'b1;
            else if (c) m_ovf[id] = 1'b0;
            if (r && mempty) m_udf[id] = 1'b1;
            else if (c) m_udf[id] = 1'b0;
            if (r && !mempty) begin
                w = q.pop_front();
                if (sa[id] == 0) m_last[id] = w;
            end
            if (p && !mfull) q.push_back(d);
        end
        case (id)
            0:       q0 = q;
            1:       q1 = q;
            default: q2 = q;
        endcase

        pfx = $sformatf("dut%0d", id);
        checkOutput({pfx, " count"}, 32'(cnt_v[id]), q.size());
        checkOutput({pfx, " full"}, 32'(full_v[id]), 32'(q.size() == DEPTH));
        checkOutput({pfx, " empty"}, 32'(empty_v[id]), 32'(q.size() == 0));
        checkOutput({pfx, " almost_full"}, 32'(af_v[id]), 32'(q.size() >= af_th[id]));
        checkOutput({pfx, " almost_empty"}, 32'(ae_v[id]), 32'(q.size() <= ae_th[id]));
        checkOutput({pfx, " overflow"}, 32'(ovf_v[id]), 32'(m_ovf[id]));
        checkOutput({pfx, " underflow"}, 32'(udf_v[id]), 32'(m_udf[id]));
        if (sa[id] == 0) begin
            checkOutput({pfx, " DataOutput"}, 32'(dout_v[id]), 32'(m_last[id]));
        end else if (q.size() > 0) begin
            checkOutput({pfx, " head"}, 32'(dout_v[id]), 32'(q[0]));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; push_v[i] = 1'b0; pop_v[i] = 1'b0;
            clr_v[i] = 1'b0; din_v[i] = '0;
        end

        // Reset with push and pop held high must still leave an empty, error-free FIFO
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
            applyStimulus(i, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        end

        // Fill, overflow, drain on the registered-read instance
        for (int i = 1; i <= DEPTH; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Pointer wrap-around
        for (int i = 0; i < 10; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 12; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Simultaneous push+pop at full, empty and mid occupancy
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h81);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h90 + i));
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h9A);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // A new error in the same cycle as clear_err keeps the flag set
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Mid-stream reset discards stored words
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Show-ahead read port
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
        checkOutput("dut1 first word", 32'(dout_v[1]), 32'hA5);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E);
        checkOutput("dut1 head before pop", 32'(dout_v[1]), 32'h3C);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("dut1 head after pop", 32'(dout_v[1]), 32'h7E);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Threshold instance: every count visited on fill and drain
        for (int i = 0; i < DEPTH; i++) applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom_range(255)));
        for (int i = 0; i < DEPTH; i++) applyStimulus(2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Random traffic on the registered and show-ahead instances
        for (int i = 0; i < 300; i++) begin
            applyStimulus(i % 2, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(15) == 0), 8'($urandom_range(255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_status.md
# sync_fifo_status

Parametrised single-clock FIFO, the next generation of the team's 8x4 FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable read mode (registered-read or show-ahead). It sits between a producer and a consumer in the same clock domain. Storage, pointers and status are internal to the block.

## Interface
- DATA_WIDTH, 8, word width in bits
- MEM_DEPTH, 16, number of entries; power of two, >= 2
- ADDR_WIDTH, CeilLog2(MEM_DEPTH), pointer width (derived; not overridden)
- AF_THRESH, MEM_DEPTH-1, almost_full asserts when count >= AF_THRESH; range 1..MEM_DEPTH
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; range 0..MEM_DEPTH-1
- SHOW_AHEAD, 0, 0 = registered read on pop; 1 = head word presented whenever not empty

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- DataInput  in  DATA_WIDTH  write data
- push  in  1  write request
- pop  in  1  read request
- clear_err  in  1  clears overflow/underflow (synchronous)
- DataOutput  out  DATA_WIDTH  read data
- full  out  1  count == MEM_DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..MEM_DEPTH
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
- Accept rules: wr_en = push & ~full; rd_en = pop & ~empty. Both are evaluated on the registered flags at the edge.
- On wr_en: mem[wr_ptr] <= DataInput; wr_ptr increments modulo MEM_DEPTH.
- On rd_en: rd_ptr increments modulo MEM_DEPTH.
- Pointers wrap naturally at MEM_DEPTH-1 -> 0.
- count update per edge: +1 if wr_en & ~rd_en; -1 if rd_en & ~wr_en; unchanged if both or neither. count never exceeds MEM_DEPTH and never goes below 0.
- Simultaneous push+pop:
  - When full: pop accepted, push rejected, overflow set; count goes MEM_DEPTH -> MEM_DEPTH-1.
  - When empty: push accepted, pop rejected, underflow set; count goes 0 -> 1.
  - Otherwise: both accepted, count unchanged.
- Errors: overflow <= 1 on push & full; underflow <= 1 on pop & empty.
  - Both are sticky until clear_err or reset.
  - If clear_err and a new error occur in the same cycle, the new error wins (flag remains 1).
- full, empty, almost_full and almost_empty are registered. Each is computed from the next value of count, so it matches count every cycle.
- SHOW_AHEAD=0: on rd_en, DataOutput <= mem[rd_ptr]. Otherwise DataOutput holds its last value.
- SHOW_AHEAD=1: DataOutput = mem[rd_ptr] combinationally. It is valid only while empty=0; on rd_en it advances to the next word.
- Memory contents are not cleared by reset; only pointers, count, flags and the DataOutput register are reset.

## Timing
- Reset (reset=1 at an edge):
  - rd_ptr, wr_ptr and count go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (0 >= AF_THRESH is impossible since AF_THRESH >= 1).
  - overflow=0, underflow=0.
  - DataOutput register=0 (SHOW_AHEAD=0).
- Reset has priority over push, pop and clear_err. Reset mid-stream discards all stored words.
- Write-to-flag latency: 1 edge. A push at edge k makes empty=0 and count=1 visible after edge k.
- Read latency:
  - SHOW_AHEAD=0: data appears after the same edge that accepts pop (1 cycle).
  - SHOW_AHEAD=1: the first word written to an empty FIFO is visible on DataOutput after the write edge, with no pop needed.
- Throughput: one push and one pop per cycle, sustained indefinitely when 0 < count < MEM_DEPTH.

## Test plan
- Reset check: assert reset with push=pop=1 for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, DataOutput=0.
- Fill/drain (DEPTH=16, SHOW_AHEAD=0):
  - Push 0x01..0x10 -> full=1 after the 16th edge; almost_full=1 from count=15.
  - 17th push -> overflow=1, count stays 16.
  - Pop 16 times -> DataOutput sequence 0x01..0x10; empty=1 after the last pop.
- Wrap-around: push 10, pop 10, push 12, pop 12 -> read order equals write order across the pointer wrap; count returns to 0.
- Simultaneous events:
  - At count=16, push+pop -> count=15, overflow=1, head word popped.
  - At count=0, push+pop -> count=1, underflow=1.
  - At count=5, push+pop -> count=5, no error.
  - Then clear_err -> both flags 0.
- Show-ahead (SHOW_AHEAD=1):
  - Push 0xA5 into an empty FIFO -> DataOutput=0xA5 after the write edge with no pop.
  - Pop -> empty=1.
  - Then push 0x3C, 0x7E and pop once -> DataOutput changes from 0x3C to 0x7E after the pop edge.
- Thresholds: AF_THRESH=12, AE_THRESH=3 -> almost_empty=1 for count 0..3, almost_full=1 for count 12..16, checked at every count on fill and on drain.
